// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency-demo controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package freq_pkg;

  typedef enum logic [1:0] {IDLE, DIV, BCD, DONE} freq_state_t;

  localparam int DIVIDEND = 100000;  // 0.01 Hz units over a 1 ms period
  localparam int DVD_W    = 17;      // width of DIVIDEND
  localparam int CYCLE_W  = 10;
  localparam int QUOT_W   = 11;      // quotient peaks at 2000
  localparam int BCD_W    = 16;
  localparam int STEP_W   = 5;       // counts DVD_W + QUOT_W converter steps

  // Double-dabble correction: add 3 to every digit that is 5 or more
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_div_bcd.sv
// Sequential DIVIDEND/divisor restoring divider followed by an 11-bit double-dabble.
// Latency: start accepted on one edge, result on bcd 28 edges later (17 divide + 11 convert).
// Backpressure: none; start is ignored while busy, the caller waits for done.
module seq_div_bcd
  import freq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CYCLE_W-1:0] divisor,
  output logic               busy,
  output logic               div_done,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  localparam logic [STEP_W-1:0] DIV_LAST = STEP_W'(DVD_W - 1);
  localparam logic [STEP_W-1:0] CNT_LAST = STEP_W'(DVD_W + QUOT_W - 1);

  logic               running;
  logic [STEP_W-1:0]  cnt;
  logic [CYCLE_W-1:0] dsr;     // latched divisor
  logic [CYCLE_W-1:0] rem;     // partial remainder, always below dsr
  logic [DVD_W-1:0]   dvd;     // dividend in, quotient out, then BCD source
  logic [BCD_W-1:0]   bcd_sr;
  logic [CYCLE_W:0]   rem_sh;
  logic [CYCLE_W-1:0] rem_sub;
  logic               fits;
  logic [BCD_W-1:0]   bcd_adj;

  // One restoring-division trial and one dabble correction per clock
  always_comb begin
    rem_sh  = {rem, dvd[DVD_W-1]};
    fits    = rem_sh >= {1'b0, dsr};
    // When fits is set the difference is below dsr, so the low bits are exact
    rem_sub = rem_sh[CYCLE_W-1:0] - dsr;
    bcd_adj = dabble_adj(bcd_sr);
  end

  // Step counter and shift registers: division first, then binary-to-BCD
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      dsr     <= '0;
      rem     <= '0;
      dvd     <= '0;
      bcd_sr  <= '0;
    end else if (start && !running) begin
      running <= 1'b1;
      cnt     <= '0;
      dsr     <= divisor;
      rem     <= '0;
      dvd     <= DVD_W'(DIVIDEND);
      bcd_sr  <= '0;
    end else if (running) begin
      cnt <= cnt + 1'b1;
      if (cnt <= DIV_LAST) begin
        rem <= fits ? rem_sub : rem_sh[CYCLE_W-1:0];
        dvd <= {dvd[DVD_W-2:0], fits};
      end else begin
        bcd_sr <= (bcd_adj << 1) | BCD_W'(dvd[QUOT_W-1]);
        dvd    <= {dvd[DVD_W-2:0], 1'b0};
      end
      if (cnt == CNT_LAST) running <= 1'b0;
    end
  end

  // Phase strobes fire during the cycle whose edge performs the last step
  always_comb begin
    busy     = running;
    div_done = running && (cnt == DIV_LAST);
    done     = running && (cnt == CNT_LAST);
    bcd      = bcd_sr;
  end

endmodule

// File: rtl/freq_ctrl.sv
// Key-driven blink period with clamping, plus BCD readout of 100000/cycle (optional auto-repeat: FREQ_CTRL_AUTOREPEAT_EN).
// Latency: key edge to cycle 2 clocks; cycle change to bcd_valid 30 clocks.
// Backpressure: none; changes during a conversion set dirty and trigger a rerun afterwards.
module freq_ctrl
  import freq_pkg::*;
#(
  parameter int CYCLE_MIN    = 50,
  parameter int CYCLE_MAX    = 1000,
  parameter int CYCLE_STEP   = 50,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1k,
  input  logic               key_slow,
  input  logic               key_fast,
  output logic [CYCLE_W-1:0] cycle,
  output logic               busy,
  output logic [BCD_W-1:0]   bcd,
  output logic               bcd_valid
);

  localparam int SUM_W = CYCLE_W + 1;

  logic               slow_q, fast_q, slow_d, fast_d;
  logic               evt_slow, evt_fast, step_up, step_dn;
  logic [SUM_W-1:0]   sum_up;
  logic [CYCLE_W-1:0] cycle_nxt;
  logic               dirty;
  freq_state_t        state_q, state_nxt;
  logic               start, load_out;
  logic               cvt_busy, cvt_div_done, cvt_done;
  logic [BCD_W-1:0]   cvt_bcd;

  // Register key levels and keep the previous sample for press detection
  always_ff @(posedge clk) begin
    if (rst) begin
      slow_q <= 1'b1;
      fast_q <= 1'b1;
      slow_d <= 1'b1;
      fast_d <= 1'b1;
    end else begin
      slow_q <= key_slow;
      fast_q <= key_fast;
      slow_d <= slow_q;
      fast_d <= fast_q;
    end
  end

  // A press counts only if the other key is released (covers simultaneous presses)
  always_comb begin
    evt_slow = slow_d & ~slow_q & fast_q;
    evt_fast = fast_d & ~fast_q & slow_q;
  end

`ifdef FREQ_CTRL_AUTOREPEAT_EN
  logic [9:0] rpt_cnt;
  logic       one_held, rpt_hit;

  // Repeat fires on the tick that brings the held time to the delay/rate mark
  always_comb begin
    one_held = slow_q ^ fast_q;
    rpt_hit  = tick_1k & one_held & (rpt_cnt == 10'(REPEAT_DELAY - 1));
    step_up  = evt_slow | (rpt_hit & ~slow_q);
    step_dn  = evt_fast | (rpt_hit & ~fast_q);
  end

  // Held-time counter in ms; reloads so later repeats come every REPEAT_RATE
  always_ff @(posedge clk) begin
    if (rst || !one_held) rpt_cnt <= '0;
    else if (tick_1k)     rpt_cnt <= rpt_hit ? 10'(REPEAT_DELAY - REPEAT_RATE) : rpt_cnt + 1'b1;
  end
`else
  logic unused_tick;
  assign unused_tick = tick_1k;

  // One step per press, no repeat
  always_comb begin
    step_up = evt_slow;
    step_dn = evt_fast;
  end
`endif

  // Clamped next period; the decrement is range-checked before subtracting
  always_comb begin
    sum_up    = SUM_W'(cycle) + SUM_W'(CYCLE_STEP);
    cycle_nxt = cycle;
    if (step_up)
      cycle_nxt = (sum_up > SUM_W'(CYCLE_MAX)) ? CYCLE_W'(CYCLE_MAX) : sum_up[CYCLE_W-1:0];
    else if (step_dn)
      cycle_nxt = (SUM_W'(cycle) >= SUM_W'(CYCLE_MIN + CYCLE_STEP)) ?
                  cycle - CYCLE_W'(CYCLE_STEP) : CYCLE_W'(CYCLE_MIN);
  end

  // Period register; dirty set on any real change, wins over a same-cycle start
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle <= CYCLE_W'(CYCLE_MAX);
      dirty <= 1'b1;
    end else begin
      cycle <= cycle_nxt;
      if (cycle_nxt != cycle) dirty <= 1'b1;
      else if (start)         dirty <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // FSM next state: the converter's strobes pace DIV and BCD
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE: if (dirty)        state_nxt = DIV;
      DIV:  if (cvt_div_done) state_nxt = BCD;
      BCD:  if (cvt_done)     state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    start    = (state_q == IDLE) && dirty;
    load_out = (state_q == DONE);
    busy     = cvt_busy | load_out;
  end

  // Published result holds between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= load_out;
      if (load_out) bcd <= cvt_bcd;
    end
  end

  seq_div_bcd u_cvt (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .divisor  (cycle),
    .busy     (cvt_busy),
    .div_done (cvt_div_done),
    .done     (cvt_done),
    .bcd      (cvt_bcd)
  );

endmodule

// File: tb/tb_freq_ctrl.sv
// Bench for freq_ctrl: fixed vectors, corner sequences and random key traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_freq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1k = 1'b0;
  logic        key_slow = 1'b1;
  logic        key_fast = 1'b1;
  logic [9:0]  cycle;
  logic        busy;
  logic [15:0] bcd;
  logic        bcd_valid;

  int n_chk = 0;
  int n_fail = 0;
  int ref_cycle;

  always #10 clk = ~clk;

  freq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1k   (tick_1k),
    .key_slow  (key_slow),
    .key_fast  (key_fast),
    .cycle     (cycle),
    .busy      (busy),
    .bcd       (bcd),
    .bcd_valid (bcd_valid)
  );

  typedef struct {
    bit          slow;
    bit          fast;
    int          exp_cycle;
    bit          exp_conv;
    logic [15:0] exp_bcd;
  } vec_t;

  // Reference: clamped step and decimal digits of 100000/period
  function automatic int model_step(input int c, input bit up);
    if (up) return (c + 50 > 1000) ? 1000 : c + 50;
    return (c - 50 < 50) ? 50 : c - 50;
  endfunction

  function automatic logic [15:0] freq_bcd(input int per);
    int f;
    f = 100000 / per;
    return {4'(f / 1000), 4'((f / 100) % 10), 4'((f / 10) % 10), 4'(f % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit s, input bit f);
    key_slow = ~s;
    key_fast = ~f;
    repeat (3) step();
    key_slow = 1'b1;
    key_fast = 1'b1;
  endtask

  // Hold one key, then press the other on top of it, then release both
  task automatic hold_other(input bit slow_first);
    if (slow_first) key_slow = 1'b0; else key_fast = 1'b0;
    repeat (3) step();
    key_slow = 1'b0;
    key_fast = 1'b0;
    repeat (3) step();
    key_slow = 1'b1;
    key_fast = 1'b1;
    repeat (2) step();
  endtask

  task automatic watch(input int n, output bit saw_v, output bit saw_b);
    saw_v = 1'b0;
    saw_b = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bcd_valid) saw_v = 1'b1;
      if (busy) saw_b = 1'b1;
    end
  endtask

  task automatic wait_valid(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (bcd_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    vec_t tbl[8];
    bit   sv, sb;
    int   lat, op, ticks, nevt;
    bit   r;

    tbl[0] = '{0, 1,  900, 1, 16'h0111};
    tbl[1] = '{1, 0,  950, 1, 16'h0105};
    tbl[2] = '{1, 0, 1000, 1, 16'h0100};
    tbl[3] = '{1, 0, 1000, 0, 16'h0100};
    tbl[4] = '{1, 1, 1000, 0, 16'h0100};
    tbl[5] = '{0, 1,  950, 1, 16'h0105};
    tbl[6] = '{0, 1,  900, 1, 16'h0111};
    tbl[7] = '{0, 1,  850, 1, 16'h0117};

    // Reset state
    repeat (2) step();
    chk("rst_cycle", 32'(cycle), 1000);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(bcd_valid), 0);
    chk("rst_bcd", 32'(bcd), 0);
    rst = 1'b0;
    wait_valid(31, lat);
    chk("rst_conv_seen", 32'(lat > 0), 1);
    chk("rst_conv_bcd", 32'(bcd), 32'h0100);
    ref_cycle = 1000;

    // Single fast press: key path and conversion latency
    key_fast = 1'b0;
    step();
    chk("key_lat_early", 32'(cycle), 1000);
    step();
    chk("key_lat_cycle", 32'(cycle), 950);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1) begin
        chk("busy_rise", 32'(busy), 1);
        key_fast = 1'b1;
      end
      if (bcd_valid && lat < 0) lat = i;
    end
    chk("conv_latency", 32'(lat), 30);
    chk("fast_bcd", 32'(bcd), 32'h0105);
    ref_cycle = 950;

    // Fixed vectors
    for (int i = 0; i < 8; i++) begin
      press(tbl[i].slow, tbl[i].fast);
      watch(40, sv, sb);
      chk($sformatf("vec%0d_cycle", i), 32'(cycle), 32'(tbl[i].exp_cycle));
      chk($sformatf("vec%0d_conv", i), 32'(sv), 32'(tbl[i].exp_conv));
      chk($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(tbl[i].exp_bcd));
      ref_cycle = tbl[i].exp_cycle;
    end

    // Press while the other key is held gives no event
    hold_other(1'b1);
    watch(40, sv, sb);
    ref_cycle = model_step(ref_cycle, 1'b1);
    chk("hold_slow_cycle", 32'(cycle), 32'(ref_cycle));
    chk("hold_slow_bcd", 32'(bcd), 32'(freq_bcd(ref_cycle)));
    hold_other(1'b0);
    watch(40, sv, sb);
    ref_cycle = model_step(ref_cycle, 1'b0);
    chk("hold_fast_cycle", 32'(cycle), 32'(ref_cycle));
    chk("hold_fast_bcd", 32'(bcd), 32'(freq_bcd(ref_cycle)));

    // Clamp at the minimum
    for (int i = 0; i < 25; i++) begin
      press(1'b0, 1'b1);
      watch(35, sv, sb);
      ref_cycle = model_step(ref_cycle, 1'b0);
      chk($sformatf("clamp%0d_cycle", i), 32'(cycle), 32'(ref_cycle));
    end
    chk("clamp_min_cycle", 32'(cycle), 50);
    chk("clamp_min_bcd", 32'(bcd), 32'h2000);
    for (int i = 0; i < 2; i++) begin
      press(1'b0, 1'b1);
      watch(35, sv, sb);
      chk($sformatf("clamp_extra%0d_valid", i), 32'(sv), 0);
      chk($sformatf("clamp_extra%0d_busy", i), 32'(sb), 0);
    end

    // Auto-repeat: hold slow across a run of 1 ms ticks
    ticks = 650;
    nevt = 1;
`ifdef FREQ_CTRL_AUTOREPEAT_EN
    if (ticks >= 500) nevt += 1 + (ticks - 500) / 100;
`endif
    key_slow = 1'b0;
    repeat (4) step();
    for (int i = 0; i < ticks; i++) begin
      tick_1k = 1'b1;
      step();
      tick_1k = 1'b0;
      repeat (3) step();
    end
    key_slow = 1'b1;
    watch(40, sv, sb);
    for (int i = 0; i < nevt; i++) ref_cycle = model_step(ref_cycle, 1'b1);
    chk("rpt_cycle", 32'(cycle), 32'(ref_cycle));
    chk("rpt_bcd", 32'(bcd), 32'(freq_bcd(ref_cycle)));

    // Random key traffic, including changes during conversions
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 3);
      r  = 1'($urandom_range(0, 1));
      case (op)
        0: begin press(1'b1, 1'b0); ref_cycle = model_step(ref_cycle, 1'b1); end
        1: begin press(1'b0, 1'b1); ref_cycle = model_step(ref_cycle, 1'b0); end
        2: press(1'b1, 1'b1);
        default: begin hold_other(r); ref_cycle = model_step(ref_cycle, r); end
      endcase
      chk($sformatf("rand%0d_cycle", n), 32'(cycle), 32'(ref_cycle));
      repeat ($urandom_range(2, 45)) step();
    end
    watch(80, sv, sb);
    chk("rand_idle", 32'(busy), 0);
    chk("rand_bcd", 32'(bcd), 32'(freq_bcd(ref_cycle)));

    // Reset in the middle of a conversion
    if (ref_cycle > 50) key_fast = 1'b0; else key_slow = 1'b0;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (busy) begin
        lat = i;
        break;
      end
    end
    chk("mid_busy_seen", 32'(lat > 0), 1);
    key_fast = 1'b1;
    key_slow = 1'b1;
    repeat (9) step();
    rst = 1'b1;
    step();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(bcd_valid), 0);
    chk("mid_rst_bcd", 32'(bcd), 0);
    chk("mid_rst_cycle", 32'(cycle), 1000);
    watch(3, sv, sb);
    chk("mid_rst_no_valid", 32'(sv), 0);
    rst = 1'b0;
    wait_valid(31, lat);
    chk("mid_reconv_seen", 32'(lat > 0), 1);
    chk("mid_reconv_bcd", 32'(bcd), 32'h0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
